seq_mult_hilo: RTL and testbench

Iterative 32x32 shift-add multiplier that produces the 64-bit product written into the HI/LO register pair. It sits in the EX stage beside the ALU and accepts one operand pair per start pulse. It runs for a fixed 32 iterations. It then presents the product together with a one-cycle HI/LO write-enable (`hilo_we`, wired to the HI/LO register's write enable) and the 64-bit `mul_ans` bus. Hazard logic uses `busy` to stall MFHI/MFLO and back-to-back MULTs.

---
 rtl/seq_mult_hilo_if.sv | 60 ++++++
 rtl/seq_mult_hilo.sv | 161 ++++++++++++++++
 tb/tb_seq_mult_hilo.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_hilo_if.sv
// ---------------------------------------------------------------------------
// seq_mult_hilo_if
//   Operand/result bundle between the EX stage and the iterative HI/LO
//   multiplier.
//
//   Handshake: start is a launch request that the multiplier accepts only
//   on a clock edge where it is idle (busy=0) and flush=0. Nothing is held
//   or queued. A request made while busy is dropped, so the requester must
//   re-present start once busy has fallen. The result is announced by a
//   single-cycle hilo_we strobe, and mul_ans is valid while it is high.
//
//   Signals
//     start     : launch request (master -> slave)
//     flush     : cancel operation in flight / suppress launch (master -> slave)
//     op_a      : multiplicand, WIDTH bits (master -> slave)
//     op_b      : multiplier, WIDTH bits (master -> slave)
//     signed_op : signed multiply request, only with MUL_SIGNED_EN defined
//     busy      : operation in flight (slave -> master)
//     hilo_we   : one-cycle HI/LO write strobe (slave -> master)
//     mul_ans   : product {HI,LO}, 2*WIDTH bits (slave -> master)
//
//   Configuration macro: MUL_SIGNED_EN (adds signed_op).
// ---------------------------------------------------------------------------
interface seq_mult_hilo_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 flush;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
`ifdef MUL_SIGNED_EN
  logic                 signed_op;
`endif
  logic                 busy;
  logic                 hilo_we;
  logic [2*WIDTH-1:0]   mul_ans;

`ifdef MUL_SIGNED_EN
  modport master (
    output start, flush, op_a, op_b, signed_op,
    input  busy, hilo_we, mul_ans
  );

  modport slave (
    input  start, flush, op_a, op_b, signed_op,
    output busy, hilo_we, mul_ans
  );
`else
  modport master (
    output start, flush, op_a, op_b,
    input  busy, hilo_we, mul_ans
  );

  modport slave (
    input  start, flush, op_a, op_b,
    output busy, hilo_we, mul_ans
  );
`endif

endinterface

// File: rtl/seq_mult_hilo.sv
// ---------------------------------------------------------------------------
// seq_mult_hilo
//   Iterative WIDTH x WIDTH shift-add multiplier for the HI/LO register
//   pair. It performs one add/shift iteration per clock, so it needs WIDTH
//   iterations. The product is registered on the last iteration edge and
//   then announced with a one-cycle hilo_we strobe.
//
//   Ports
//     clk       : rising-edge clock
//     reset     : asynchronous, active-low reset
//     bus       : seq_mult_hilo_if.slave (start/flush/op_a/op_b[/signed_op]
//                 in, busy/hilo_we/mul_ans out)
//     dbg_state : current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
//   Configuration macro: MUL_SIGNED_EN
//     When it is defined, signed_op=1 selects a signed multiply. The datapath
//     multiplies the operand magnitudes, and the product is negated on the
//     last edge when exactly one operand was negative. Latency is the same
//     as for an unsigned multiply.
// ---------------------------------------------------------------------------
module seq_mult_hilo #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  seq_mult_hilo_if.slave     bus,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [CW-1:0]        cnt;
  logic                 busy_q;
  logic                 we_q;
  logic [2*WIDTH-1:0]   ans_q;

  // Operand values as they are loaded, and the final product value.
  logic [WIDTH-1:0]     load_a;
  logic [WIDTH-1:0]     load_b;
  logic [2*WIDTH-1:0]   result;

  // One iteration: a conditional add with its carry, then a shift right of
  // {carry, acc_hi, acc_lo}. The carry bit lands in the top of acc_hi.
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     hi_nxt;
  logic [WIDTH-1:0]     lo_nxt;
  logic [2*WIDTH-1:0]   prod_nxt;

  always_comb begin
    sum      = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      sum    = {1'b0, acc_hi} + {1'b0, mcand};
    end
    hi_nxt   = sum[WIDTH:1];
    lo_nxt   = {sum[0], acc_lo[WIDTH-1:1]};
    prod_nxt = {hi_nxt, lo_nxt};
  end

`ifdef MUL_SIGNED_EN
  logic neg;
  logic a_neg;
  logic b_neg;

  // The most negative operand negates to itself. Read as unsigned, that is
  // already its correct magnitude (2^(WIDTH-1)).
  always_comb begin
    a_neg  = bus.signed_op & bus.op_a[WIDTH-1];
    b_neg  = bus.signed_op & bus.op_b[WIDTH-1];
    load_a = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    load_b = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
    result = neg ? (~prod_nxt + 1'b1) : prod_nxt;
  end
`else
  always_comb begin
    load_a = bus.op_a;
    load_b = bus.op_b;
    result = prod_nxt;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      we_q   <= 1'b0;
      ans_q  <= '0;
`ifdef MUL_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          we_q <= 1'b0;
          // flush takes priority over start, so a squashed launch never starts.
          if (bus.start && !bus.flush) begin
            mcand  <= load_a;
            acc_hi <= '0;
            acc_lo <= load_b;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
`ifdef MUL_SIGNED_EN
            neg    <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
`endif
          end
        end

        RUN: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            we_q   <= 1'b0;
          end else begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              ans_q <= result;
              we_q  <= 1'b1;
              state <= DONE;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          we_q   <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          we_q   <= 1'b0;
        end
      endcase
    end
  end

  // A squash during the DONE cycle must suppress the HI/LO write in that
  // same cycle. The registered strobe is therefore qualified by flush.
  assign bus.hilo_we = we_q & ~bus.flush;
  assign bus.busy    = busy_q;
  assign bus.mul_ans = ans_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_seq_mult_hilo.sv
module tb_seq_mult_hilo;

  logic        clk;
  logic        reset;
  logic [1:0]  dbg_state;

  int          n_checks;
  int          n_errors;
  logic [63:0] exp_q[$];
  logic [63:0] last_ans;
  logic        prev_we;

  seq_mult_hilo_if #(.WIDTH(32)) mul_if();

  seq_mult_hilo #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mul_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    if (sgn) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return {32'b0, a} * {32'b0, b};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mul_if.hilo_we === 1'b1) begin
      if (prev_we) check("we_double", 64'd1, 64'd0);
      if (exp_q.size() == 0) check("we_unexpected", 64'd1, 64'd0);
      else check("mul_ans", mul_if.mul_ans, exp_q.pop_front());
    end
    prev_we = (mul_if.hilo_we === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic set_signed(input logic sgn);
`ifdef MUL_SIGNED_EN
    mul_if.signed_op = sgn;
`else
    if (sgn) $display("signed request ignored in unsigned build");
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (mul_if.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 64'd0, 64'd1);
  endtask

  // Counts negedges after the current one until hilo_we is seen.
  task automatic wait_we(output int lat);
    lat = 1;
    while (mul_if.hilo_we !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int lat;
    wait_idle();
    mul_if.op_a  = a;
    mul_if.op_b  = b;
    set_signed(sgn);
    mul_if.start = 1'b1;
    exp_q.push_back(model(a, b, sgn));
    last_ans = model(a, b, sgn);
    @(negedge clk);
    mul_if.start = 1'b0;
    check("busy_on", 64'(mul_if.busy), 64'd1);
    wait_we(lat);
    check("latency", 64'(lat), 64'd33);
    check("busy_in_done", 64'(mul_if.busy), 64'd1);
    @(negedge clk);
    check("busy_off", 64'(mul_if.busy), 64'd0);
    check("we_off", 64'(mul_if.hilo_we), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    prev_we  = 1'b0;
    last_ans = '0;
    mul_if.start = 1'b0;
    mul_if.flush = 1'b0;
    mul_if.op_a  = '0;
    mul_if.op_b  = '0;
    set_signed(1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(mul_if.busy), 64'd0);
    check("rst_we", 64'(mul_if.hilo_we), 64'd0);
    check("rst_ans", mul_if.mul_ans, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;

    // basic and boundary products
    run_mul(32'd3, 32'd5, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mul(32'h1234_5678, 32'd0, 1'b0);
    run_mul(32'd1, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 5; i++) run_mul($urandom, $urandom, 1'b0);
    run_mul($urandom_range(0, 255), $urandom_range(0, 255), 1'b0);

    // start held high across the whole operation
    wait_idle();
    mul_if.op_a  = 32'd7;
    mul_if.op_b  = 32'd9;
    mul_if.start = 1'b1;
    exp_q.push_back(64'd63);
    @(negedge clk);
    mul_if.op_a = 32'd11;
    mul_if.op_b = 32'd13;
    check("hold_busy_on", 64'(mul_if.busy), 64'd1);
    wait_we(lat);
    check("hold_latency", 64'(lat), 64'd33);
    @(negedge clk);
    check("hold_busy_fall", 64'(mul_if.busy), 64'd0);
    exp_q.push_back(64'd143);
    @(negedge clk);
    check("hold_relaunch", 64'(mul_if.busy), 64'd1);
    mul_if.start = 1'b0;
    wait_we(lat);
    check("hold_latency2", 64'(lat), 64'd33);
    last_ans = 64'd143;

    // flush while idle overrides start
    wait_idle();
    mul_if.start = 1'b1;
    mul_if.flush = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    mul_if.flush = 1'b0;
    check("flush_idle_busy", 64'(mul_if.busy), 64'd0);

    // flush at cycle 10 of RUN
    wait_idle();
    mul_if.op_a  = 32'h1000;
    mul_if.op_b  = 32'h10;
    mul_if.start = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    repeat (9) @(negedge clk);
    mul_if.flush = 1'b1;
    @(negedge clk);
    mul_if.flush = 1'b0;
    check("flush_run_busy", 64'(mul_if.busy), 64'd0);
    check("flush_run_state", 64'(dbg_state), 64'd0);
    check("flush_run_ans", mul_if.mul_ans, last_ans);
    repeat (40) @(negedge clk);
    check("flush_run_ans_hold", mul_if.mul_ans, last_ans);

    // flush during the DONE cycle suppresses the write strobe
    wait_idle();
    mul_if.op_a  = 32'd9;
    mul_if.op_b  = 32'd9;
    mul_if.start = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    repeat (31) @(negedge clk);
    @(posedge clk);
    #1 mul_if.flush = 1'b1;
    @(negedge clk);
    check("flush_done_we", 64'(mul_if.hilo_we), 64'd0);
    check("flush_done_ans", mul_if.mul_ans, 64'd81);
    @(posedge clk);
    #1 mul_if.flush = 1'b0;
    @(negedge clk);
    check("flush_done_busy", 64'(mul_if.busy), 64'd0);
    last_ans = 64'd81;

    // asynchronous reset mid-operation
    wait_idle();
    mul_if.op_a  = 32'd5;
    mul_if.op_b  = 32'd6;
    mul_if.start = 1'b1;
    @(negedge clk);
    mul_if.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(mul_if.busy), 64'd0);
    check("arst_we", 64'(mul_if.hilo_we), 64'd0);
    check("arst_ans", mul_if.mul_ans, 64'd0);
    check("arst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_mul(32'd2, 32'd2, 1'b0);

`ifdef MUL_SIGNED_EN
    run_mul(32'hFFFF_FFFE, 32'd3, 1'b1);
    run_mul(32'h8000_0000, 32'h8000_0000, 1'b1);
    run_mul(32'h8000_0000, 32'd1, 1'b1);
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, 1'b1);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
